// File: rtl/jtarget_skid_buf_pkg.sv
// Shared definitions for the jump-target skid buffer.
//   JT_WIDTH      : default payload width (jump target field, 26 bits)
//   state_t       : buffer state; the encoding equals the entry count
//   EMPTY/ONE/TWO : the three buffer states
//   st_in_ready   : ready-to-accept for a given state
//   st_out_valid  : output-valid for a given state
package jtarget_skid_buf_pkg;

    localparam int JT_WIDTH = 26;

    typedef logic [1:0] state_t;

    localparam state_t EMPTY = 2'd0;
    localparam state_t ONE   = 2'd1;
    localparam state_t TWO   = 2'd2;

    function automatic logic st_in_ready(input state_t st);
        return (st != TWO);
    endfunction

    function automatic logic st_out_valid(input state_t st);
        return (st != EMPTY);
    endfunction

endpackage

// File: rtl/jtarget_hs_checker.sv
// Upstream handshake checker for the jump-target skid buffer.
// Flags an offer that was stalled (in_valid & !in_ready) and then either
// withdrawn or altered in the following cycle before being accepted.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : discards the pending-offer tracking (proto_err is kept)
//   in_valid    : upstream offer valid
//   in_ready    : buffer ready as seen by upstream
//   in_data     : upstream payload
//   proto_err   : sticky violation flag, cleared only by reset
module jtarget_hs_checker
    import jtarget_skid_buf_pkg::*;
#(
    parameter int WIDTH = JT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             proto_err
);

    logic             r_pending;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic             w_violation;

    // A stalled offer from the previous cycle must reappear unchanged.
    assign w_violation = r_pending && (!in_valid || (in_data != r_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else if (flush) begin
            // Redirect: whatever upstream was offering is moot now.
            r_pending <= 1'b0;
        end else begin
            r_pending <= in_valid && !in_ready;
            r_data    <= in_data;
            if (w_violation) begin
                r_err <= 1'b1;
            end
        end
    end

    assign proto_err = r_err;

endmodule

// File: rtl/jtarget_skid_buf.sv
// Two-entry elastic (skid) buffer on the 26-bit jump-target path.
// Accepts targets from upstream with valid/ready and presents them in FIFO
// order to the fetch/PC-select logic. in_ready, out_valid and out_data are
// all driven straight from registers; full throughput is kept by the skid
// register absorbing the one entry that arrives while the output stalls.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : drop all held entries (branch redirect)
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_data             : upstream target
//   out_valid/out_ready : downstream handshake (out_valid registered)
//   out_data            : oldest held entry (registered)
//   occupancy           : number of held entries, 0..2
//   proto_err           : sticky upstream handshake violation
module jtarget_skid_buf
    import jtarget_skid_buf_pkg::*;
#(
    parameter int WIDTH = JT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic             proto_err
);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    state_t           w_state_next;
    logic             w_accept;
    logic             w_pop;
    logic             w_main_from_in;
    logic             w_main_from_skid;
    logic             w_skid_from_in;

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_out_valid && out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;

        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_next   = ONE;
                    w_main_from_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_main_from_in = 1'b1;
                end else if (w_accept) begin
                    // Output stalled: park the newcomer behind the head.
                    w_state_next   = TWO;
                    w_skid_from_in = 1'b1;
                end else if (w_pop) begin
                    w_state_next   = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_state_next     = ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase

        // Redirect wins over any same-cycle transfer; storage is left as is.
        if (flush) begin
            w_state_next     = EMPTY;
            w_main_from_in   = 1'b0;
            w_main_from_skid = 1'b0;
            w_skid_from_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_next;
            // Handshake outputs are precomputed from the next state so they
            // come directly from flops.
            r_in_ready  <= st_in_ready(w_state_next);
            r_out_valid <= st_out_valid(w_state_next);
            if (w_main_from_in) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_state;

    jtarget_hs_checker #(
        .WIDTH (WIDTH)
    ) u_hs_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (r_in_ready),
        .in_data   (in_data),
        .proto_err (proto_err)
    );

endmodule

// File: tb/tb_jtarget_skid_buf.sv
// Self-checking bench for jtarget_skid_buf: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_jtarget_skid_buf;

    localparam int W = 26;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
    logic         proto_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic         m_in_ready;
    logic         m_err;
    logic         m_pend;
    logic [W-1:0] m_pend_d;
    logic         last_acc;

    jtarget_skid_buf #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_in_ready = 1'b0;
        m_err      = 1'b0;
        m_pend     = 1'b0;
        m_pend_d   = '0;
        last_acc   = 1'b0;
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        logic acc, pp;
        if (flush) begin
            q.delete();
            m_pend   = 1'b0;
            last_acc = 1'b0;
        end else begin
            if (m_pend && (!in_valid || in_data !== m_pend_d)) m_err = 1'b1;
            m_pend   = in_valid && !m_in_ready;
            m_pend_d = in_data;
            acc = in_valid && m_in_ready;
            pp  = out_ready && (q.size() > 0);
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(in_data);
            last_acc = acc;
        end
        m_in_ready = (q.size() < 2);
    endtask

    task automatic check_all(input string tag);
        logic [1:0] exp_occ;
        exp_occ = 2'(q.size());
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(exp_occ));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(m_in_ready));
        chk({tag, ".proto_err"}, 32'(proto_err), 32'(m_err));
        if (q.size() > 0) chk({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
        $display("%-12s v=%0b d=%07h rdy=%0b fl=%0b | ov=%0b od=%07h ir=%0b occ=%0d pe=%0b",
                 tag, in_valid, in_data, out_ready, flush,
                 out_valid, out_data, in_ready, occupancy, proto_err);
    endtask

    task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic         cur_v;
        logic [W-1:0] cur_d;
        logic         cur_fl;
        logic         cur_rdy;

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;

        // Reset / idle
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst.out_valid", 32'(out_valid), 32'd0);
            chk("rst.out_data",  32'(out_data),  32'd0);
            chk("rst.occupancy", 32'(occupancy), 32'd0);
            chk("rst.proto_err", 32'(proto_err), 32'd0);
            chk("rst.in_ready",  32'(in_ready),  32'd0);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rel.in_ready_before_edge", 32'(in_ready), 32'd0);
        step("rel", 1'b0, '0, 1'b0, 1'b0);
        chk("rel.in_ready_after_edge", 32'(in_ready), 32'd1);

        // Streaming with out_ready=1
        for (int i = 1; i <= 8; i++) begin
            step("stream", 1'b1, W'(i), 1'b1, 1'b0);
            chk("stream.out_data", 32'(out_data), 32'(i));
        end
        step("drain", 1'b0, '0, 1'b1, 1'b0);

        // Backpressure
        step("bp0", 1'b1, 26'h3FFFFFF, 1'b0, 1'b0);
        step("bp1", 1'b1, 26'h1234567, 1'b0, 1'b0);
        chk("bp.full_occ", 32'(occupancy), 32'd2);
        chk("bp.full_head", 32'(out_data), 32'h3FFFFFF);
        step("bp_hold", 1'b0, '0, 1'b0, 1'b0);
        chk("bp.hold_head", 32'(out_data), 32'h3FFFFFF);
        step("bp_pop0", 1'b0, '0, 1'b1, 1'b0);
        chk("bp.second", 32'(out_data), 32'h1234567);
        step("bp_pop1", 1'b0, '0, 1'b1, 1'b0);

        // Simultaneous accept+pop, then flush with accept
        step("sim_aa", 1'b1, 26'h00000AA, 1'b0, 1'b0);
        step("sim_bb", 1'b1, 26'h00000BB, 1'b1, 1'b0);
        chk("sim.bb_head", 32'(out_data), 32'h00000BB);
        step("sim_fl_cc", 1'b1, 26'h00000CC, 1'b1, 1'b1);
        step("sim_idle", 1'b0, '0, 1'b1, 1'b0);
        chk("sim.no_cc", 32'(out_valid), 32'd0);

        // Randomized phase with a well-behaved upstream (stalled offers held)
        cur_v = 1'b0; cur_d = '0; cur_fl = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(cur_v && !last_acc && !cur_fl)) begin
                cur_v = 1'($urandom % 2);
                cur_d = W'($urandom);
            end
            cur_rdy = ($urandom % 4) != 0;
            cur_fl  = ($urandom % 16) == 0;
            step("rand", cur_v, cur_d, cur_rdy, cur_fl);
        end
        step("rand_fl", 1'b0, '0, 1'b1, 1'b1);

        // Protocol error
        step("pe_fill0", 1'b1, 26'h0000001, 1'b0, 1'b0);
        step("pe_fill1", 1'b1, 26'h0000002, 1'b0, 1'b0);
        step("pe_stall", 1'b1, 26'h0000005, 1'b0, 1'b0);
        chk("pe.not_yet", 32'(proto_err), 32'd0);
        step("pe_change", 1'b1, 26'h0000006, 1'b0, 1'b0);
        chk("pe.set", 32'(proto_err), 32'd1);
        step("pe_flush", 1'b0, '0, 1'b1, 1'b1);
        chk("pe.sticky_flush", 32'(proto_err), 32'd1);
        step("pe_idle", 1'b0, '0, 1'b1, 1'b0);

        // Async reset mid-operation
        step("ar_fill0", 1'b1, 26'h0000011, 1'b0, 1'b0);
        step("ar_fill1", 1'b1, 26'h0000022, 1'b0, 1'b0);
        chk("ar.full", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar.out_valid", 32'(out_valid), 32'd0);
        chk("ar.occupancy", 32'(occupancy), 32'd0);
        chk("ar.proto_err", 32'(proto_err), 32'd0);
        chk("ar.in_ready",  32'(in_ready),  32'd0);
        chk("ar.out_data",  32'(out_data),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        step("ar_rel", 1'b0, '0, 1'b1, 1'b0);
        step("ar_push", 1'b1, 26'h2AAAAAA, 1'b1, 1'b0);
        step("ar_drain", 1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
